// File: rtl/ppwm_pkg.sv
// Shared constants, opcode/state types and decode helpers for the ppwm instruction sequencer.
package ppwm_pkg;

    localparam int unsigned INSTR_W = 6;
    localparam int unsigned PC_W    = 5;
    localparam int unsigned VALUE_W = 10;
    localparam int unsigned IMM_W   = 4;

    typedef enum logic [1:0] {
        OP_LDH  = 2'b00,
        OP_ADD  = 2'b01,
        OP_WAIT = 2'b10,
        OP_JMP  = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        WAIT  = 2'b10
    } state_e;

    function automatic opcode_e instr_op(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[INSTR_W-1:IMM_W]);
    endfunction

    function automatic logic [IMM_W-1:0] instr_imm(input logic [INSTR_W-1:0] instr);
        return instr[IMM_W-1:0];
    endfunction

endpackage

// File: rtl/ppwm_seq_alu.sv
// Next-accumulator logic for LDH/ADD. Defining PPWM_SEQ_SATURATE_EN makes ADD clamp to
// 0..2**VALUE_W-1 instead of wrapping modulo 2**VALUE_W.
module ppwm_seq_alu #(
    parameter int unsigned VALUE_W = 10
) (
    input  logic [VALUE_W-1:0]            acc_i,
    input  logic [ppwm_pkg::IMM_W-1:0]    imm_i,
    input  ppwm_pkg::opcode_e             op_i,
    output logic [VALUE_W-1:0]            acc_o
);
    import ppwm_pkg::*;

    localparam int unsigned LDH_SHIFT = VALUE_W - IMM_W;

`ifdef PPWM_SEQ_SATURATE_EN
    // Two guard bits: top bit flags underflow, next flags overflow past the max code.
    logic signed [VALUE_W+1:0] sum;
    assign sum = $signed({2'b00, acc_i}) + $signed({{(VALUE_W-2){imm_i[IMM_W-1]}}, imm_i});
`else
    logic [VALUE_W-1:0] sum;
    assign sum = acc_i + {{(VALUE_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
`endif

    always_comb begin
        acc_o = acc_i;
        unique case (op_i)
            OP_LDH: acc_o = {imm_i, {LDH_SHIFT{1'b0}}};
            OP_ADD: begin
`ifdef PPWM_SEQ_SATURATE_EN
                if (sum[VALUE_W+1]) begin
                    acc_o = '0;
                end else if (sum[VALUE_W]) begin
                    acc_o = '1;
                end else begin
                    acc_o = sum[VALUE_W-1:0];
                end
`else
                acc_o = sum;
`endif
            end
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/ppwm_seq.sv
// Accumulator-ISA sequencer feeding the PWM compare value, paced by PWM period starts.
// Optional macro PPWM_SEQ_SATURATE_EN (handled in ppwm_seq_alu) selects saturating ADD.
module ppwm_seq #(
    parameter int unsigned VALUE_W = 10,
    parameter int unsigned PC_W    = 5,
    parameter int unsigned WAIT_W  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            programmed_i,
    input  logic [ppwm_pkg::INSTR_W-1:0]    instr_i,
    input  logic                            period_start_i,
    output logic [PC_W-1:0]                 pc_o,
    output logic [VALUE_W-1:0]              pwm_value_o,
    output logic                            running_o
);
    import ppwm_pkg::*;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [VALUE_W-1:0]  acc_q, acc_d;
    logic [VALUE_W-1:0]  pwm_q, pwm_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    opcode_e             op;
    logic [IMM_W-1:0]    imm;
    logic [VALUE_W-1:0]  acc_alu;

    assign op  = instr_op(instr_i);
    assign imm = instr_imm(instr_i);

    ppwm_seq_alu #(
        .VALUE_W (VALUE_W)
    ) u_alu (
        .acc_i (acc_q),
        .imm_i (imm),
        .op_i  (op),
        .acc_o (acc_alu)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        pwm_d      = pwm_q;
        wait_cnt_d = wait_cnt_q;

        // Loss of programmed_i means the memory is being rewritten: restart cleanly.
        if (!programmed_i) begin
            state_d    = IDLE;
            pc_d       = '0;
            acc_d      = '0;
            pwm_d      = '0;
            wait_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    unique case (op)
                        OP_LDH, OP_ADD: begin
                            acc_d = acc_alu;
                            pc_d  = pc_q + PC_W'(1);
                        end
                        OP_WAIT: begin
                            pwm_d      = acc_q;
                            wait_cnt_d = WAIT_W'(imm);
                            pc_d       = pc_q + PC_W'(1);
                            state_d    = WAIT;
                        end
                        OP_JMP: begin
                            pc_d = PC_W'({imm, 1'b0});
                        end
                        default: pc_d = pc_q;
                    endcase
                end
                WAIT: begin
                    if (period_start_i) begin
                        if (wait_cnt_q == '0) begin
                            state_d = FETCH;
                        end else begin
                            wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            acc_q      <= '0;
            pwm_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            pwm_q      <= pwm_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc_o        = pc_q;
    assign pwm_value_o = pwm_q;
    assign running_o   = (state_q == FETCH) || (state_q == WAIT);

endmodule

// File: tb/tb_ppwm_seq.sv
// Self-checking bench for ppwm_seq: directed scenarios plus randomized programs, all compared
// every cycle against an integer-level model of the instruction set.
module tb_ppwm_seq;

    localparam int unsigned VALUE_W = 10;
    localparam int unsigned PC_W    = 5;
    localparam int unsigned WAIT_W  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               programmed_i;
    logic               period_start_i;
    logic [5:0]         instr_i;
    logic [PC_W-1:0]    pc_o;
    logic [VALUE_W-1:0] pwm_value_o;
    logic               running_o;

    logic [5:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign instr_i = mem[pc_o];

    ppwm_seq #(
        .VALUE_W (VALUE_W),
        .PC_W    (PC_W),
        .WAIT_W  (WAIT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .programmed_i   (programmed_i),
        .instr_i        (instr_i),
        .period_start_i (period_start_i),
        .pc_o           (pc_o),
        .pwm_value_o    (pwm_value_o),
        .running_o      (running_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = idle, 1 = executing, 2 = holding for m_left more period pulses.
    int m_mode = 0, m_pc = 0, m_acc = 0, m_pwm = 0, m_left = 0;
    int m_op, m_imm, m_simm;

    always @(posedge clk or posedge rst) begin
        if (rst || !programmed_i) begin
            m_mode = 0; m_pc = 0; m_acc = 0; m_pwm = 0; m_left = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_op   = int'(mem[m_pc]) / 16;
            m_imm  = int'(mem[m_pc]) % 16;
            m_simm = (m_imm >= 8) ? m_imm - 16 : m_imm;
            case (m_op)
                0: begin m_acc = m_imm * 64; m_pc = (m_pc + 1) % 32; end
                1: begin
                    m_acc = m_acc + m_simm;
`ifdef PPWM_SEQ_SATURATE_EN
                    if (m_acc < 0) m_acc = 0;
                    if (m_acc > 1023) m_acc = 1023;
`else
                    m_acc = (m_acc + 1024) % 1024;
`endif
                    m_pc = (m_pc + 1) % 32;
                end
                2: begin m_pwm = m_acc; m_left = m_imm + 1; m_pc = (m_pc + 1) % 32; m_mode = 2; end
                default: m_pc = m_imm * 2;
            endcase
        end else if (period_start_i) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model pc", 32'(pc_o), m_pc);
            check("model pwm", 32'(pwm_value_o), m_pwm);
            check("model running", 32'(running_o), 32'(m_mode != 0));
        end
    end

    task automatic reprogram();
        programmed_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) mem[i] = 6'h00;
    endtask

    task automatic pulse();
        period_start_i = 1'b1;
        @(negedge clk);
        period_start_i = 1'b0;
    endtask

    int exp_sat1, exp_sat2;

    initial begin
`ifdef PPWM_SEQ_SATURATE_EN
        exp_sat1 = 1023; exp_sat2 = 0;
`else
        exp_sat1 = 6;    exp_sat2 = 1016;
`endif
        for (int i = 0; i < 32; i++) mem[i] = 6'h00;
        rst = 1'b0; programmed_i = 1'b0; period_start_i = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset and idle
        repeat (10) @(negedge clk);
        check("idle pc", 32'(pc_o), 0);
        check("idle pwm", 32'(pwm_value_o), 0);
        check("idle running", 32'(running_o), 0);

        // Basic program: LDH 8, WAIT 0, ADD +1, JMP 0
        mem[0] = 6'h08; mem[1] = 6'h20; mem[2] = 6'h11; mem[3] = 6'h30;
        programmed_i = 1'b1;
        @(negedge clk);
        check("start running", 32'(running_o), 1);
        check("start pc", 32'(pc_o), 0);
        @(negedge clk);
        check("after ldh pc", 32'(pc_o), 1);
        @(negedge clk);
        check("wait pwm", 32'(pwm_value_o), 512);
        check("wait pc", 32'(pc_o), 2);
        repeat (5) @(negedge clk);
        check("hold pc", 32'(pc_o), 2);
        pulse();
        check("release pc", 32'(pc_o), 2);
        @(negedge clk); check("loop pc3", 32'(pc_o), 3);
        @(negedge clk); check("loop pc0", 32'(pc_o), 0);
        @(negedge clk); check("loop pc1", 32'(pc_o), 1);
        @(negedge clk); check("loop pwm", 32'(pwm_value_o), 512);

        // WAIT 3; pulse coincident with the execute cycle must not count
        reprogram();
        mem[0] = 6'h23; mem[1] = 6'h30;
        programmed_i = 1'b1;
        @(negedge clk);
        pulse();
        check("wait3 exec pc", 32'(pc_o), 1);
        for (int k = 1; k <= 3; k++) begin
            repeat (19) @(negedge clk);
            pulse();
        end
        @(negedge clk);
        check("wait3 still held", 32'(pc_o), 1);
        repeat (18) @(negedge clk);
        pulse();
        check("wait3 release pc", 32'(pc_o), 1);
        @(negedge clk);
        check("wait3 refetch pc", 32'(pc_o), 0);

        // Saturate/wrap, reprogram mid-WAIT, self-jump, async reset
        reprogram();
        mem[0] = 6'h0F;
        for (int i = 1; i <= 10; i++) mem[i] = 6'h17;
        mem[11] = 6'h20; mem[12] = 6'h00; mem[13] = 6'h18; mem[14] = 6'h20;
        mem[15] = 6'h38; mem[16] = 6'h38;
        programmed_i = 1'b1;
        repeat (13) @(negedge clk);
        check("add overflow pwm", 32'(pwm_value_o), 32'(exp_sat1));
        check("add overflow pc", 32'(pc_o), 12);
        programmed_i = 1'b0;
        @(negedge clk);
        check("reprog pc", 32'(pc_o), 0);
        check("reprog pwm", 32'(pwm_value_o), 0);
        check("reprog running", 32'(running_o), 0);
        programmed_i = 1'b1;
        @(negedge clk);
        check("restart pc", 32'(pc_o), 0);
        repeat (12) @(negedge clk);
        check("rerun pwm", 32'(pwm_value_o), 32'(exp_sat1));
        pulse();
        repeat (3) @(negedge clk);
        check("add underflow pwm", 32'(pwm_value_o), 32'(exp_sat2));
        pulse();
        repeat (4) @(negedge clk);
        check("self jmp pc", 32'(pc_o), 16);
        check("self jmp running", 32'(running_o), 1);
        check("self jmp pwm", 32'(pwm_value_o), 32'(exp_sat2));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst pc", 32'(pc_o), 0);
        check("async rst pwm", 32'(pwm_value_o), 0);
        check("async rst running", 32'(running_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized programs and pacing
        reprogram();
        for (int i = 0; i < 32; i++) mem[i] = 6'($urandom);
        programmed_i = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            period_start_i = ($urandom_range(0, 3) == 0);
            programmed_i   = ($urandom_range(0, 299) != 0);
            if (!programmed_i) begin
                for (int i = 0; i < 32; i++) mem[i] = 6'($urandom);
            end
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
